// File: rtl/lcd_glyph_engine_if.sv
// Host command channel of the glyph engine: valid/ready handshake plus
// the command fields and the reserved-op error pulse.
interface lcd_glyph_engine_if #(
  parameter int ROM_AW = 10
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ROM_AW-1:0] cmd_rom_base;
  logic [3:0]        cmd_col;
  logic              cmd_row;
  logic [2:0]        cmd_slot;
  logic              cmd_err;

  modport master (
    output cmd_valid, cmd_op, cmd_rom_base, cmd_col, cmd_row, cmd_slot,
    input  cmd_ready, cmd_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rom_base, cmd_col, cmd_row, cmd_slot,
    output cmd_ready, cmd_err
  );
endinterface

// File: rtl/lcd_glyph_engine.sv
// HD44780 8-bit character-LCD engine: power-up init, CGRAM glyph load from
// an external ROM, tile drawing with edge clipping, and display clear.
// All bus timing is counted in clk cycles.
module lcd_glyph_engine #(
  parameter int N_SLOTS = 8,
  parameter int TILE_W  = 4,
  parameter int TILE_H  = 2,
  parameter int ROM_AW  = 10,
  parameter int T_POWER = 750000,
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 25,
  parameter int T_CMD   = 2500,
  parameter int T_CLEAR = 85000
) (
  input  logic                clk,
  input  logic                reset,
  lcd_glyph_engine_if.slave   cmd,
  output logic [ROM_AW-1:0]   rom_addr,
  input  logic [7:0]          rom_data,
  output logic                lcd_rs,
  output logic                lcd_rw,
  output logic                lcd_en,
  output logic [7:0]          lcd_data,
  output logic                init_done
);
  localparam int T_A     = (T_POWER > T_CLEAR) ? T_POWER : T_CLEAR;
  localparam int T_B     = (T_CMD > T_PULSE) ? T_CMD : T_PULSE;
  localparam int T_C     = (T_A > T_B) ? T_A : T_B;
  localparam int T_MAX   = (T_C > T_SETUP) ? T_C : T_SETUP;
  localparam int CW      = $clog2(T_MAX + 1);
  localparam int IW      = 7;
  localparam int N_BYTES = N_SLOTS * 8;

  typedef enum logic [2:0] {S_POWERUP, S_INIT, S_IDLE, S_LOAD, S_TILE, S_CLEAR} state_t;
  typedef enum logic [1:0] {W_OFF, W_SETUP, W_PULSE, W_HOLD} wphase_t;

  state_t            state_q, state_d;
  wphase_t           wphase_q, wphase_d;
  logic [CW-1:0]     wcnt_q, wcnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [1:0]        t_r_q, t_r_d;
  logic [4:0]        t_k_q, t_k_d;
  logic              t_cur_q, t_cur_d;
  logic [ROM_AW-1:0] base_q, base_d;
  logic [3:0]        col_q, col_d;
  logic              row_q, row_d;
  logic [2:0]        slot_q, slot_d;
  logic              rs_q, rs_d;
  logic [7:0]        data_q, data_d;
  logic [ROM_AW-1:0] addr_q, addr_d;
  logic              rom_fetch_q, rom_fetch_d;
  logic              init_done_q, init_done_d;
  logic              err_q, err_d;

  logic              ready;
  logic              wr_last;
  logic              issue;
  logic              issue_rs;
  logic              issue_rom;
  logic [7:0]        issue_data;
  logic [CW-1:0]     hold_last;
  logic [5:0]        k_next;
  logic [5:0]        col_sum;
  logic [1:0]        r_next;
  logic [1:0]        row_sum;

  function automatic logic [7:0] tile_byte(input logic [2:0] slot,
                                           input logic [1:0] r,
                                           input logic [5:0] k);
    logic [2:0] code;
    code = slot + 3'(int'(r) * TILE_W) + k[2:0];
    return {5'd0, code};
  endfunction

  function automatic logic [7:0] cursor_cmd(input logic line, input logic [3:0] c);
    return {1'b1, line, 2'b00, c};
  endfunction

  assign ready     = (state_q == S_IDLE) && !err_q;
  assign hold_last = (!rs_q && data_q == 8'h01) ? CW'(T_CLEAR - 1) : CW'(T_CMD - 1);
  assign k_next    = 6'(t_k_q) + 6'd1;
  assign col_sum   = 6'(col_q) + k_next;
  assign r_next    = t_r_q + 2'd1;
  assign row_sum   = {1'b0, row_q} + r_next;

  assign cmd.cmd_ready = ready;
  assign cmd.cmd_err   = err_q;
  assign rom_addr      = addr_q;
  assign lcd_rs        = rs_q;
  assign lcd_rw        = 1'b0;
  assign lcd_en        = (wphase_q == W_PULSE);
  assign lcd_data      = data_q;
  assign init_done     = init_done_q;

  // Next-state logic: write-engine phase sequencing, then the command FSM,
  // which may queue the next write on the very edge the current HOLD ends.
  always_comb begin
    state_d     = state_q;
    wphase_d    = wphase_q;
    wcnt_d      = wcnt_q;
    idx_d       = idx_q;
    t_r_d       = t_r_q;
    t_k_d       = t_k_q;
    t_cur_d     = t_cur_q;
    base_d      = base_q;
    col_d       = col_q;
    row_d       = row_q;
    slot_d      = slot_q;
    rs_d        = rs_q;
    data_d      = data_q;
    addr_d      = addr_q;
    rom_fetch_d = rom_fetch_q;
    init_done_d = init_done_q;
    err_d       = 1'b0;
    wr_last     = 1'b0;
    issue       = 1'b0;
    issue_rs    = 1'b0;
    issue_rom   = 1'b0;
    issue_data  = '0;

    unique case (wphase_q)
      W_SETUP: begin
        // ROM address went out on the first SETUP cycle; its data is latched
        // so it is on the bus from the second SETUP cycle onward.
        if (rom_fetch_q && wcnt_q == '0) data_d = rom_data;
        if (wcnt_q == CW'(T_SETUP - 1)) begin
          wphase_d = W_PULSE;
          wcnt_d   = '0;
        end else begin
          wcnt_d = wcnt_q + CW'(1);
        end
      end
      W_PULSE: begin
        if (wcnt_q == CW'(T_PULSE - 1)) begin
          wphase_d = W_HOLD;
          wcnt_d   = '0;
        end else begin
          wcnt_d = wcnt_q + CW'(1);
        end
      end
      W_HOLD: begin
        if (wcnt_q == hold_last) begin
          wr_last  = 1'b1;
          wphase_d = W_OFF;
          wcnt_d   = '0;
        end else begin
          wcnt_d = wcnt_q + CW'(1);
        end
      end
      default: ;
    endcase

    unique case (state_q)
      S_POWERUP: begin
        if (wcnt_q == CW'(T_POWER - 1)) begin
          state_d    = S_INIT;
          idx_d      = '0;
          issue      = 1'b1;
          issue_data = 8'h38;
        end else begin
          wcnt_d = wcnt_q + CW'(1);
        end
      end
      S_INIT: begin
        if (wr_last) begin
          if (idx_q == IW'(3)) begin
            init_done_d = 1'b1;
            idx_d       = IW'(4);
          end else begin
            idx_d = idx_q + IW'(1);
            issue = 1'b1;
            case (idx_q)
              IW'(0):  issue_data = 8'h0C;
              IW'(1):  issue_data = 8'h06;
              default: issue_data = 8'h01;
            endcase
          end
        end else if (wphase_q == W_OFF && idx_q == IW'(4)) begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (cmd.cmd_valid && ready) begin
          base_d = cmd.cmd_rom_base;
          col_d  = cmd.cmd_col;
          row_d  = cmd.cmd_row;
          slot_d = cmd.cmd_slot;
          idx_d  = '0;
          case (cmd.cmd_op)
            2'd0: begin
              state_d    = S_LOAD;
              issue      = 1'b1;
              issue_data = 8'h40;
            end
            2'd1: begin
              state_d    = S_TILE;
              t_r_d      = '0;
              t_k_d      = '0;
              t_cur_d    = 1'b1;
              issue      = 1'b1;
              issue_data = cursor_cmd(cmd.cmd_row, cmd.cmd_col);
            end
            2'd2: begin
              state_d    = S_CLEAR;
              issue      = 1'b1;
              issue_data = 8'h01;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      S_LOAD: begin
        if (wr_last) begin
          idx_d = idx_q + IW'(1);
          if (idx_q < IW'(N_BYTES)) begin
            issue     = 1'b1;
            issue_rs  = 1'b1;
            issue_rom = 1'b1;
            addr_d    = base_q + ROM_AW'(idx_q);
          end else if (idx_q == IW'(N_BYTES)) begin
            issue      = 1'b1;
            issue_data = 8'h80;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_TILE: begin
        // Walk cursor, then columns of the row; clipped columns end the row,
        // clipped rows end the tile.
        if (wr_last) begin
          if (t_cur_q) begin
            t_cur_d    = 1'b0;
            t_k_d      = '0;
            issue      = 1'b1;
            issue_rs   = 1'b1;
            issue_data = tile_byte(slot_q, t_r_q, 6'd0);
          end else if (k_next < 6'(TILE_W) && col_sum <= 6'd15) begin
            t_k_d      = k_next[4:0];
            issue      = 1'b1;
            issue_rs   = 1'b1;
            issue_data = tile_byte(slot_q, t_r_q, k_next);
          end else if (r_next < 2'(TILE_H) && row_sum <= 2'd1) begin
            t_r_d      = r_next;
            t_cur_d    = 1'b1;
            issue      = 1'b1;
            issue_data = cursor_cmd(row_sum[0], col_q);
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_CLEAR: begin
        if (wr_last) state_d = S_IDLE;
      end
      default: state_d = S_POWERUP;
    endcase

    if (issue) begin
      wphase_d    = W_SETUP;
      wcnt_d      = '0;
      rs_d        = issue_rs;
      data_d      = issue_data;
      rom_fetch_d = issue_rom;
    end
  end

  // State register with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_POWERUP;
      wphase_q    <= W_OFF;
      wcnt_q      <= '0;
      idx_q       <= '0;
      t_r_q       <= '0;
      t_k_q       <= '0;
      t_cur_q     <= 1'b0;
      base_q      <= '0;
      col_q       <= '0;
      row_q       <= 1'b0;
      slot_q      <= '0;
      rs_q        <= 1'b0;
      data_q      <= '0;
      addr_q      <= '0;
      rom_fetch_q <= 1'b0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wphase_q    <= wphase_d;
      wcnt_q      <= wcnt_d;
      idx_q       <= idx_d;
      t_r_q       <= t_r_d;
      t_k_q       <= t_k_d;
      t_cur_q     <= t_cur_d;
      base_q      <= base_d;
      col_q       <= col_d;
      row_q       <= row_d;
      slot_q      <= slot_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      addr_q      <= addr_d;
      rom_fetch_q <= rom_fetch_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
    end
  end
endmodule

// File: tb/tb_lcd_glyph_engine.sv
// Scoreboard bench for lcd_glyph_engine: commands push the expected LCD write
// list (from a loop-level model) into a queue; a monitor pops on each lcd_en
// rising edge and compares.
module tb_lcd_glyph_engine;
  localparam int ROM_AW  = 10;
  localparam int N_SLOTS = 2;
  localparam int TILE_W  = 4;
  localparam int TILE_H  = 2;
  localparam int T_POWER = 20;
  localparam int T_SETUP = 2;
  localparam int T_PULSE = 3;
  localparam int T_CMD   = 5;
  localparam int T_CLEAR = 10;
  localparam int INIT_DONE_AT = T_POWER + 3 * (T_SETUP + T_PULSE + T_CMD)
                              + T_SETUP + T_PULSE + T_CLEAR;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [ROM_AW-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic              lcd_rs, lcd_rw, lcd_en, init_done;
  logic [7:0]        lcd_data;
  logic [7:0]        rom_mem [1 << ROM_AW];

  wr_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  logic en_prev = 1'b0;
  int   width = 0;
  bit   abort_pulse = 1'b0;

  always #5 clk = ~clk;

  assign rom_data = rom_mem[rom_addr];

  lcd_glyph_engine_if #(.ROM_AW(ROM_AW)) cmd_if ();

  lcd_glyph_engine #(
    .N_SLOTS(N_SLOTS), .TILE_W(TILE_W), .TILE_H(TILE_H), .ROM_AW(ROM_AW),
    .T_POWER(T_POWER), .T_SETUP(T_SETUP), .T_PULSE(T_PULSE),
    .T_CMD(T_CMD), .T_CLEAR(T_CLEAR)
  ) dut (
    .clk(clk), .reset(reset), .cmd(cmd_if),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
    .lcd_data(lcd_data), .init_done(init_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void push_wr(input logic rs, input int data);
    wr_t w;
    w.rs   = rs;
    w.data = 8'(data);
    exp_q.push_back(w);
  endfunction

  function automatic void model_init();
    push_wr(1'b0, 'h38);
    push_wr(1'b0, 'h0C);
    push_wr(1'b0, 'h06);
    push_wr(1'b0, 'h01);
  endfunction

  function automatic void model_cmd(input int op, input int base, input int col,
                                    input int row, input int slot);
    case (op)
      0: begin
        push_wr(1'b0, 'h40);
        for (int i = 0; i < N_SLOTS * 8; i++)
          push_wr(1'b1, rom_mem[(base + i) % (1 << ROM_AW)]);
        push_wr(1'b0, 'h80);
      end
      1: begin
        for (int r = 0; r < TILE_H; r++) begin
          if (row + r <= 1) begin
            push_wr(1'b0, 'h80 + 'h40 * (row + r) + col);
            for (int k = 0; k < TILE_W; k++)
              if (col + k <= 15) push_wr(1'b1, (slot + r * TILE_W + k) % 8);
          end
        end
      end
      2: push_wr(1'b0, 'h01);
      default: ;
    endcase
  endfunction

  // Monitor: every enable rising edge must match the head of the scoreboard.
  always @(negedge clk) begin
    wr_t e;
    if (lcd_en && !en_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got rs=%0d data=0x%02h, expected no write", lcd_rs, lcd_data);
      end else begin
        e = exp_q.pop_front();
        check("write_rs_data", 32'({lcd_rs, lcd_data}), 32'(e));
      end
      check("ready_low_during_write", 32'(cmd_if.cmd_ready), 32'd0);
      check("rw_low", 32'(lcd_rw), 32'd0);
    end
    if (lcd_en) begin
      width++;
    end else begin
      if (width > 0) begin
        if (!abort_pulse) check("pulse_width", width, T_PULSE);
        abort_pulse = 1'b0;
      end
      width = 0;
    end
    en_prev = lcd_en;
  end

  task automatic check_reset_state();
    check("rst_en", 32'(lcd_en), 0);
    check("rst_rs", 32'(lcd_rs), 0);
    check("rst_data", 32'(lcd_data), 0);
    check("rst_rom_addr", 32'(rom_addr), 0);
    check("rst_ready", 32'(cmd_if.cmd_ready), 0);
    check("rst_init_done", 32'(init_done), 0);
    check("rst_err", 32'(cmd_if.cmd_err), 0);
  endtask

  // Called right after reset is released at a negedge; counts edges from there.
  task automatic wait_init();
    int first_en = -1, done_at = -1, ready_at = -1;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk);
      #1;
      if (first_en < 0 && lcd_en) first_en = n;
      if (done_at < 0 && init_done) done_at = n;
      if (cmd_if.cmd_ready) begin
        ready_at = n;
        break;
      end
    end
    check("init_first_en", first_en, T_POWER + T_SETUP);
    check("init_done_at", done_at, INIT_DONE_AT);
    check("init_ready_at", ready_at, INIT_DONE_AT + 1);
    check("init_queue_drained", exp_q.size(), 0);
  endtask

  task automatic send_cmd(input int op, input int base, input int col,
                          input int row, input int slot);
    int w = 0, gap = -1;
    logic prev;
    model_cmd(op, base, col, row, slot);
    @(negedge clk);
    cmd_if.cmd_op       = 2'(op);
    cmd_if.cmd_rom_base = ROM_AW'(base);
    cmd_if.cmd_col      = 4'(col);
    cmd_if.cmd_row      = 1'(row);
    cmd_if.cmd_slot     = 3'(slot);
    cmd_if.cmd_valid    = 1'b1;
    while (!cmd_if.cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("ready_before_accept", 32'(cmd_if.cmd_ready), 1);
    @(posedge clk);
    #1;
    cmd_if.cmd_valid    = 1'b0;
    cmd_if.cmd_op       = 2'($urandom);
    cmd_if.cmd_rom_base = ROM_AW'($urandom);
    cmd_if.cmd_col      = 4'($urandom);
    cmd_if.cmd_row      = 1'($urandom);
    cmd_if.cmd_slot     = 3'($urandom);
    check("ready_drops", 32'(cmd_if.cmd_ready), 0);
    check("err_pulse", 32'(cmd_if.cmd_err), 32'(op == 3));
    if (op == 3) begin
      @(posedge clk);
      #1;
      check("err_clears", 32'(cmd_if.cmd_err), 0);
      check("ready_after_err", 32'(cmd_if.cmd_ready), 1);
      return;
    end
    prev = lcd_en;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      if (prev && !lcd_en) gap = 0;
      else if (gap >= 0) gap++;
      prev = lcd_en;
      if (cmd_if.cmd_ready) break;
    end
    check("cmd_done_in_time", 32'(cmd_if.cmd_ready), 1);
    check("final_hold", gap, (op == 2) ? T_CLEAR : T_CMD);
    check("cmd_queue_drained", exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #2000000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int k, seen;
    logic pe;
    for (int a = 0; a < (1 << ROM_AW); a++) rom_mem[a] = 8'(a);
    reset               = 1'b1;
    cmd_if.cmd_valid    = 1'b0;
    cmd_if.cmd_op       = '0;
    cmd_if.cmd_rom_base = '0;
    cmd_if.cmd_col      = '0;
    cmd_if.cmd_row      = 1'b0;
    cmd_if.cmd_slot     = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state();
    model_init();
    @(negedge clk);
    reset = 1'b0;
    wait_init();

    send_cmd(0, 'h3F8, 0, 0, 0);
    send_cmd(1, 0, 14, 1, 6);
    send_cmd(1, 0, 0, 0, 0);
    send_cmd(3, 0, 0, 0, 0);
    send_cmd(2, 0, 0, 0, 0);

    for (int a = 0; a < (1 << ROM_AW); a++) rom_mem[a] = 8'($urandom);
    for (int i = 0; i < 30; i++)
      send_cmd($urandom_range(0, 3), $urandom_range(0, (1 << ROM_AW) - 1),
               $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 7));

    // Reset in the middle of an enable pulse during a glyph load.
    model_cmd(0, 'h3FC, 0, 0, 0);
    @(negedge clk);
    cmd_if.cmd_op       = 2'd0;
    cmd_if.cmd_rom_base = ROM_AW'('h3FC);
    cmd_if.cmd_valid    = 1'b1;
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    k    = $urandom_range(2, 10);
    seen = 0;
    pe   = lcd_en;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (lcd_en && !pe) seen++;
      pe = lcd_en;
      if (seen == k) break;
    end
    check("pulse_seen_before_reset", 32'(lcd_en), 1);
    abort_pulse = 1'b1;
    reset       = 1'b1;
    @(posedge clk);
    #1;
    check_reset_state();
    exp_q.delete();
    model_init();
    @(negedge clk);
    reset = 1'b0;
    wait_init();
    send_cmd(1, 0, 15, 0, 3);
    send_cmd(2, 0, 0, 0, 0);

    repeat (5) @(posedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lcd_glyph_engine.md
Name: lcd_glyph_engine

Overview:
Parametrised HD44780 character-LCD engine in 8-bit mode. It runs the power-up init sequence on its own, then serves host commands over a valid/ready handshake:
- load a glyph set from an external glyph ROM into CGRAM;
- draw a TILE_W x TILE_H block of custom characters at a given position;
- clear the display.

All bus timing (setup, enable pulse, execution wait) is cycle-counted on clk, with no derived clocks. It sits between the pet-state logic and the LCD pins.

Parameters:
- N_SLOTS, 8: CGRAM glyphs loaded per load command (1..8).
- TILE_W, 4: tile width in characters.
- TILE_H, 2: tile height in rows (1..2).
- ROM_AW, 10: glyph ROM address width.
- T_POWER, 750000: cycles waited after reset before the first write.
- T_SETUP, 2: cycles rs/data are stable before lcd_en rises (>=2).
- T_PULSE, 25: cycles lcd_en is high.
- T_CMD, 2500: wait cycles after lcd_en falls, ordinary write.
- T_CLEAR, 85000: wait cycles after lcd_en falls for command 0x01.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  host command present.
- cmd_ready  out  1  engine idle and able to accept.
- cmd_op  in  2  0 = load glyphs, 1 = draw tile, 2 = clear, 3 = reserved.
- cmd_rom_base  in  ROM_AW  glyph ROM start address (op 0).
- cmd_col  in  4  tile left column 0..15 (op 1).
- cmd_row  in  1  tile top row (op 1).
- cmd_slot  in  3  first CGRAM code used by the tile (op 1).
- rom_addr  out  ROM_AW  glyph ROM address.
- rom_data  in  8  glyph row data; valid 1 cycle after rom_addr.
- lcd_rs  out  1  register select.
- lcd_rw  out  1  tied 0 (write only).
- lcd_en  out  1  enable strobe.
- lcd_data  out  8  LCD data bus.
- init_done  out  1  init sequence complete (sticky until reset).
- cmd_err  out  1  one-cycle pulse on acceptance of op 3.

Behaviour:
- Reset (synchronous, active-high; the same when asserted mid-operation, including mid-pulse): on the next edge lcd_en=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00, rom_addr=0, cmd_ready=0, init_done=0, cmd_err=0. All counters clear and the FSM enters POWERUP. Reset has priority over all events.
- Write engine: each LCD write runs three phases, SETUP (en=0) for T_SETUP cycles, PULSE (en=1) for T_PULSE cycles, then HOLD (en=0) for T_CMD cycles, or T_CLEAR if rs=0 and data=0x01.
  - lcd_rs and lcd_data are driven at the first SETUP cycle and stay constant through the end of HOLD.
  - The next write starts on the cycle after HOLD ends.
- Top FSM states: POWERUP, INIT, IDLE, LOAD, TILE, CLEAR, with transitions in this order:
  - POWERUP: waits T_POWER cycles, then goes to INIT.
  - INIT: writes commands 0x38, 0x0C, 0x06, 0x01, sets init_done, then goes to IDLE.
  - IDLE: cmd_ready=1.
- Handshake:
  - A command is accepted on a cycle with cmd_valid && cmd_ready.
  - All cmd_* fields are captured on that edge.
  - cmd_ready is 0 from the next cycle until the engine returns to IDLE.
  - cmd_ready is never 1 outside IDLE.
- LOAD (op 0):
  - Writes command 0x40.
  - Then writes N_SLOTS*8 data bytes (rs=1). Byte i is rom_data read at rom_addr = cmd_rom_base + i.
  - rom_addr is set on the first SETUP cycle; lcd_data is loaded from rom_data on the second SETUP cycle.
  - The ROM address wraps modulo 2^ROM_AW.
  - Finally writes command 0x80 so the address counter points back to DDRAM.
  - Total: N_SLOTS*8 + 2 writes.
- TILE (op 1):
  - For each row r in 0..TILE_H-1 with cmd_row + r <= 1:
    - Write the cursor command 0x80 + 0x40*(cmd_row+r) + cmd_col.
    - Then, for each column k in 0..TILE_W-1 with cmd_col + k <= 15, write data byte (cmd_slot + r*TILE_W + k) mod 8.
  - Clipped rows emit no cursor write. Clipped columns emit no data write.
  - cmd_col = 15 with TILE_W = 4 therefore gives one data write per row.
- CLEAR (op 2): one write of 0x01 with the T_CLEAR wait.
- Op 3: no LCD activity. cmd_err pulses for the cycle after acceptance, and cmd_ready returns 1 on the following cycle.
- cmd_valid asserted during POWERUP or INIT is ignored (not accepted) until IDLE.

Test Plan:
(Bench parameters: T_POWER=20, T_SETUP=2, T_PULSE=3, T_CMD=5, T_CLEAR=10, N_SLOTS=2, TILE_W=4, TILE_H=2.)
- Reset released -> lcd_en first rises 22 cycles later with data 0x38 and rs=0. The sequence is 0x38, 0x0C, 0x06, 0x01. init_done rises after the 0x01 HOLD of 10 cycles (total 20+10+10+10+15 cycles), and cmd_ready=1 on the next cycle.
- Op 0, base=0x3F8, ROM[a]=a[7:0] -> writes 0x40, then 16 data bytes 0xF8..0xFF, 0x00..0x07 (address wraps at 0x3FF to 0x000), then 0x80. That is 18 enable pulses of 3 cycles each, and cmd_ready is 0 throughout.
- Op 1, col=14, row=1, slot=6 -> exactly 3 writes: 0xCE, then 0x06, 0x07. Row 2 is clipped.
- Op 1, col=0, row=0, slot=0 -> writes 0x80, 00, 01, 02, 03, 0xC0, 04, 05, 06, 07. rs is 0 only on the two cursor writes.
- Op 3 -> cmd_err pulses for 1 cycle, no lcd_en activity, cmd_ready returns after 2 cycles. Then op 2 -> a single 0x01 write with a 10-cycle HOLD.
- Reset asserted while lcd_en=1 during LOAD -> on the next edge lcd_en=0, data=0x00 and cmd_ready=0. The full POWERUP/INIT sequence repeats.
